// File: rtl/divider_pkg.sv
// Shared types, widths and sign helpers for the sequential divider.
package divider_pkg;

  // Controller states.
  typedef enum logic [1:0] {
    StIdle,
    StCalc,
    StFix,
    StDone
  } div_state_e;

  // Widest operand the sign helpers handle; callers size-cast in and out.
  localparam int unsigned MaxW = 64;

  // Default operand width and its bit-counter width.
  localparam int unsigned DefWidth = 13;
  localparam int unsigned DefCntW  = $clog2(DefWidth + 1);

  // Counter width able to hold the value w (the step count).
  function automatic int unsigned cnt_width(input int unsigned w);
    return $clog2(w + 1);
  endfunction

  // Conditionally negate a two's-complement value.
  function automatic logic [MaxW-1:0] apply_sign(input logic [MaxW-1:0] v, input logic neg);
    return neg ? (~v + MaxW'(1)) : v;
  endfunction

  // Magnitude of a value whose sign is flagged by neg.
  function automatic logic [MaxW-1:0] magnitude(input logic [MaxW-1:0] v, input logic neg);
    return apply_sign(v, neg);
  endfunction

endpackage

// File: rtl/div_restore_step.sv
// One combinational restoring-division step over a 2*WIDTH-bit partial remainder.
// The upper half holds the running remainder, the lower half the dividend bits
// still to be shifted in.
module div_restore_step #(
  parameter int unsigned WIDTH = 13
) (
  input  logic [2*WIDTH-1:0] rem_i,
  input  logic [WIDTH-1:0]   divisor_i,
  output logic [2*WIDTH-1:0] rem_o,
  output logic               q_bit_o
);

  logic [WIDTH:0] cand;
  logic [WIDTH:0] diff;
  logic [WIDTH-1:0] hi_next;

  // Shift left by one; the carry out of the upper half is kept as bit WIDTH so the
  // trial subtraction against the divisor is exact.
  always_comb begin
    cand    = rem_i[2*WIDTH-1:WIDTH-1];
    diff    = cand - {1'b0, divisor_i};
    q_bit_o = ~diff[WIDTH];
    hi_next = q_bit_o ? diff[WIDTH-1:0] : cand[WIDTH-1:0];
    rem_o   = {hi_next, rem_i[WIDTH-2:0], 1'b0};
  end

endmodule

// File: rtl/seq_divider.sv
// Iterative restoring divider with valid/ready handshakes, signed/unsigned mode,
// pass-through tag and divide-by-zero / overflow flags. Fixed latency: the result
// appears WIDTH+1 edges after the accepting edge.
module seq_divider
  import divider_pkg::*;
#(
  parameter int unsigned WIDTH = 13,
  parameter int unsigned TAG_W = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic             in_signed_i,
  input  logic [WIDTH-1:0] in_dividend_i,
  input  logic [WIDTH-1:0] in_divisor_i,
  input  logic [TAG_W-1:0] in_tag_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] out_quotient_o,
  output logic [WIDTH-1:0] out_remainder_o,
  output logic [TAG_W-1:0] out_tag_o,
  output logic             out_div_zero_o,
  output logic             out_overflow_o
);

  localparam int unsigned CntW = cnt_width(WIDTH);

  div_state_e state_q, state_d;
  logic [CntW-1:0]    cnt_q, cnt_d;
  logic [2*WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0]   quo_q, quo_d;
  logic [WIDTH-1:0]   dvsr_q, dvsr_d;
  logic [WIDTH-1:0]   dvd_q, dvd_d;
  logic               q_neg_q, q_neg_d;
  logic               r_neg_q, r_neg_d;
  logic               dz_q, dz_d;
  logic               ovf_q, ovf_d;
  logic [TAG_W-1:0]   tag_q, tag_d;

  logic [WIDTH-1:0]   oq_q, oq_d;
  logic [WIDTH-1:0]   or_q, or_d;
  logic [TAG_W-1:0]   otag_q, otag_d;
  logic               odz_q, odz_d;
  logic               oovf_q, oovf_d;

  logic               accept;
  logic               dvd_neg, dvs_neg;
  logic [WIDTH-1:0]   dvd_mag, dvs_mag;
  logic [2*WIDTH-1:0] step_rem;
  logic               step_q;

  div_restore_step #(
    .WIDTH(WIDTH)
  ) u_step (
    .rem_i    (rem_q),
    .divisor_i(dvsr_q),
    .rem_o    (step_rem),
    .q_bit_o  (step_q)
  );

  // Handshake and operand decode for the request being offered this cycle.
  always_comb begin
    in_ready_o = (state_q == StIdle) | ((state_q == StDone) & out_ready_i);
    accept     = in_valid_i & in_ready_o;
    dvd_neg    = in_signed_i & in_dividend_i[WIDTH-1];
    dvs_neg    = in_signed_i & in_divisor_i[WIDTH-1];
    dvd_mag    = WIDTH'(magnitude(MaxW'(in_dividend_i), dvd_neg));
    dvs_mag    = WIDTH'(magnitude(MaxW'(in_divisor_i), dvs_neg));
  end

  // Next-state logic: load on accept, iterate in CALC, sign-fix and register in FIX.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    dvsr_d  = dvsr_q;
    dvd_d   = dvd_q;
    q_neg_d = q_neg_q;
    r_neg_d = r_neg_q;
    dz_d    = dz_q;
    ovf_d   = ovf_q;
    tag_d   = tag_q;
    oq_d    = oq_q;
    or_d    = or_q;
    otag_d  = otag_q;
    odz_d   = odz_q;
    oovf_d  = oovf_q;

    unique case (state_q)
      StIdle: ;
      StCalc: begin
        rem_d = step_rem;
        quo_d = {quo_q[WIDTH-2:0], step_q};
        cnt_d = cnt_q - CntW'(1);
        if (cnt_q == CntW'(1)) state_d = StFix;
      end
      StFix: begin
        otag_d = tag_q;
        odz_d  = dz_q;
        oovf_d = ovf_q;
        if (dz_q) begin
          oq_d = '1;
          or_d = dvd_q;
        end else if (ovf_q) begin
          oq_d = {1'b1, {(WIDTH-1){1'b0}}};
          or_d = '0;
        end else begin
          oq_d = WIDTH'(apply_sign(MaxW'(quo_q), q_neg_q));
          or_d = WIDTH'(apply_sign(MaxW'(rem_q[2*WIDTH-1:WIDTH]), r_neg_q));
        end
        state_d = StDone;
      end
      StDone: begin
        if (out_ready_i) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    // Accept overrides the DONE->IDLE return for back-to-back operation.
    if (accept) begin
      rem_d   = {{WIDTH{1'b0}}, dvd_mag};
      quo_d   = '0;
      dvsr_d  = dvs_mag;
      dvd_d   = in_dividend_i;
      q_neg_d = dvd_neg ^ dvs_neg;
      r_neg_d = dvd_neg;
      dz_d    = (in_divisor_i == '0);
      ovf_d   = in_signed_i & (in_dividend_i == {1'b1, {(WIDTH-1){1'b0}}}) &
                (in_divisor_i == '1);
      tag_d   = in_tag_i;
      cnt_d   = CntW'(WIDTH);
      state_d = StCalc;
    end
  end

  // State, datapath and output registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      dvsr_q  <= '0;
      dvd_q   <= '0;
      q_neg_q <= 1'b0;
      r_neg_q <= 1'b0;
      dz_q    <= 1'b0;
      ovf_q   <= 1'b0;
      tag_q   <= '0;
      oq_q    <= '0;
      or_q    <= '0;
      otag_q  <= '0;
      odz_q   <= 1'b0;
      oovf_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      dvsr_q  <= dvsr_d;
      dvd_q   <= dvd_d;
      q_neg_q <= q_neg_d;
      r_neg_q <= r_neg_d;
      dz_q    <= dz_d;
      ovf_q   <= ovf_d;
      tag_q   <= tag_d;
      oq_q    <= oq_d;
      or_q    <= or_d;
      otag_q  <= otag_d;
      odz_q   <= odz_d;
      oovf_q  <= oovf_d;
    end
  end

  // Outputs come straight from registers; no path from in_valid to out_valid.
  always_comb begin
    out_valid_o     = (state_q == StDone);
    out_quotient_o  = oq_q;
    out_remainder_o = or_q;
    out_tag_o       = otag_q;
    out_div_zero_o  = odz_q;
    out_overflow_o  = oovf_q;
  end

endmodule

// File: tb/tb_seq_divider.sv
// Directed, table-driven bench for seq_divider (WIDTH=13, TAG_W=4).
module tb_seq_divider;

  localparam int unsigned W = 13;
  localparam int unsigned T = 4;
  localparam int Lat = 14;

  typedef struct {
    logic         sgn;
    logic [W-1:0] dvd;
    logic [W-1:0] dvs;
    logic [T-1:0] tag;
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dz;
    logic         ovf;
  } vec_t;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic         in_signed;
  logic [W-1:0] in_dividend;
  logic [W-1:0] in_divisor;
  logic [T-1:0] in_tag;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_quotient;
  logic [W-1:0] out_remainder;
  logic [T-1:0] out_tag;
  logic         out_div_zero;
  logic         out_overflow;

  int n_vec  = 0;
  int n_fail = 0;

  vec_t vecs[13];

  seq_divider #(
    .WIDTH(W),
    .TAG_W(T)
  ) dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .in_valid_i     (in_valid),
    .in_ready_o     (in_ready),
    .in_signed_i    (in_signed),
    .in_dividend_i  (in_dividend),
    .in_divisor_i   (in_divisor),
    .in_tag_i       (in_tag),
    .out_valid_o    (out_valid),
    .out_ready_i    (out_ready),
    .out_quotient_o (out_quotient),
    .out_remainder_o(out_remainder),
    .out_tag_o      (out_tag),
    .out_div_zero_o (out_div_zero),
    .out_overflow_o (out_overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Offer a request, then scramble the inputs so only the accept edge matters.
  task automatic issue(input vec_t v);
    for (int i = 0; i < 50 && !in_ready; i++) begin
      @(posedge clk);
      #1;
    end
    in_valid    = 1'b1;
    in_signed   = v.sgn;
    in_dividend = v.dvd;
    in_divisor  = v.dvs;
    in_tag      = v.tag;
    @(posedge clk);
    #1;
    in_valid    = 1'b0;
    in_signed   = 1'($urandom);
    in_dividend = W'($urandom);
    in_divisor  = W'($urandom);
    in_tag      = T'($urandom);
  endtask

  // Count edges after the accept edge until out_valid, then check the result.
  task automatic wait_check(input vec_t v, input string name);
    int lat;
    bit seen;
    seen = 1'b0;
    lat  = 0;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk);
      #1;
      if (out_valid) begin
        seen = 1'b1;
        lat  = i;
        break;
      end
    end
    check({name, " latency"}, seen ? lat : 99, Lat);
    if (seen) begin
      check({name, " quotient"}, 32'(out_quotient), 32'(v.q));
      check({name, " remainder"}, 32'(out_remainder), 32'(v.r));
      check({name, " tag"}, 32'(out_tag), 32'(v.tag));
      check({name, " div_zero"}, 32'(out_div_zero), 32'(v.dz));
      check({name, " overflow"}, 32'(out_overflow), 32'(v.ovf));
    end
  endtask

  task automatic drain(input string name);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check({name, " drained"}, 32'(out_valid), 32'd0);
  endtask

  initial begin
    vec_t bp1, bp2, rs1, rs2;

    //           sgn  dividend    divisor     tag    quotient    remainder   dz    ovf
    vecs[0]  = '{1'b0, 13'd100,    13'd7,      4'd3,  13'd14,     13'd2,      1'b0, 1'b0};
    vecs[1]  = '{1'b1, 13'h1F9C,   13'd7,      4'd5,  13'h1FF2,   13'h1FFE,   1'b0, 1'b0};
    vecs[2]  = '{1'b1, 13'd100,    13'h1FF9,   4'd6,  13'h1FF2,   13'd2,      1'b0, 1'b0};
    vecs[3]  = '{1'b0, 13'd55,     13'd0,      4'd7,  13'h1FFF,   13'd55,     1'b1, 1'b0};
    vecs[4]  = '{1'b1, 13'h1000,   13'h1FFF,   4'd8,  13'h1000,   13'd0,      1'b0, 1'b1};
    vecs[5]  = '{1'b0, 13'h1FFF,   13'd1,      4'd9,  13'h1FFF,   13'd0,      1'b0, 1'b0};
    vecs[6]  = '{1'b0, 13'h1FFF,   13'h1FFF,   4'd10, 13'd1,      13'd0,      1'b0, 1'b0};
    vecs[7]  = '{1'b1, 13'h1F9C,   13'h1FF9,   4'd11, 13'd14,     13'h1FFE,   1'b0, 1'b0};
    vecs[8]  = '{1'b0, 13'd5,      13'd9,      4'd12, 13'd0,      13'd5,      1'b0, 1'b0};
    vecs[9]  = '{1'b1, 13'h1000,   13'd1,      4'd13, 13'h1000,   13'd0,      1'b0, 1'b0};
    vecs[10] = '{1'b0, 13'h1000,   13'h1FFF,   4'd14, 13'd0,      13'h1000,   1'b0, 1'b0};
    vecs[11] = '{1'b1, 13'd7,      13'd0,      4'd15, 13'h1FFF,   13'd7,      1'b1, 1'b0};
    vecs[12] = '{1'b1, 13'h1F9C,   13'd0,      4'd1,  13'h1FFF,   13'h1F9C,   1'b1, 1'b0};

    bp1 = '{1'b0, 13'd1000, 13'd3,  4'd9,  13'd333, 13'd1, 1'b0, 1'b0};
    bp2 = '{1'b0, 13'd200,  13'd9,  4'd10, 13'd22,  13'd2, 1'b0, 1'b0};
    rs1 = '{1'b0, 13'd300,  13'd4,  4'd2,  13'd75,  13'd0, 1'b0, 1'b0};
    rs2 = '{1'b0, 13'd77,   13'd5,  4'd4,  13'd15,  13'd2, 1'b0, 1'b0};

    rst_n       = 1'b0;
    in_valid    = 1'b0;
    in_signed   = 1'b0;
    in_dividend = '0;
    in_divisor  = '0;
    in_tag      = '0;
    out_ready   = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    check("reset out_valid", 32'(out_valid), 32'd0);
    check("reset in_ready", 32'(in_ready), 32'd1);
    check("reset quotient", 32'(out_quotient), 32'd0);
    check("reset remainder", 32'(out_remainder), 32'd0);
    check("reset tag", 32'(out_tag), 32'd0);
    check("reset flags", 32'({out_div_zero, out_overflow}), 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < 13; i++) begin
      issue(vecs[i]);
      check($sformatf("vec%0d in_ready busy", i), 32'(in_ready), 32'd0);
      wait_check(vecs[i], $sformatf("vec%0d", i));
      drain($sformatf("vec%0d", i));
    end

    // Backpressure: result and tag hold, in_ready stays low.
    issue(bp1);
    wait_check(bp1, "bp1");
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      check($sformatf("bp hold%0d valid", i), 32'(out_valid), 32'd1);
      check($sformatf("bp hold%0d quotient", i), 32'(out_quotient), 32'(bp1.q));
      check($sformatf("bp hold%0d tag", i), 32'(out_tag), 32'(bp1.tag));
      check($sformatf("bp hold%0d in_ready", i), 32'(in_ready), 32'd0);
    end
    // Release together with a new request: consumed and accepted on one edge.
    out_ready   = 1'b1;
    in_valid    = 1'b1;
    in_signed   = bp2.sgn;
    in_dividend = bp2.dvd;
    in_divisor  = bp2.dvs;
    in_tag      = bp2.tag;
    #1;
    check("b2b in_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    out_ready   = 1'b0;
    in_valid    = 1'b0;
    in_dividend = W'($urandom);
    in_divisor  = W'($urandom);
    check("b2b out_valid fell", 32'(out_valid), 32'd0);
    check("b2b in_ready busy", 32'(in_ready), 32'd0);
    wait_check(bp2, "bp2");
    drain("bp2");

    // Reset during CALC discards the in-flight divide.
    issue(rs1);
    repeat (6) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("midreset out_valid", 32'(out_valid), 32'd0);
    check("midreset in_ready", 32'(in_ready), 32'd1);
    check("midreset quotient", 32'(out_quotient), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("post reset in_ready", 32'(in_ready), 32'd1);
    check("post reset out_valid", 32'(out_valid), 32'd0);
    issue(rs2);
    wait_check(rs2, "after reset");
    drain("after reset");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
